// File: rtl/left_shifter.sv
// Purpose : registered left shifter; zero-extends an 8-bit operand and shifts it by 0, 4 or 8 bits.
// Latency : 1 cycle; inputs sampled at a rising edge appear on shift_out right after that edge.
// Backpressure: none; a new result is loaded every cycle, with no enable or handshake.
//
// Ports:
//   clk         - sole clock, rising edge
//   rst         - synchronous active-high reset; clears shift_out to 0
//   inp         - 8-bit unsigned operand
//   shift_cntrl - shift select: 00 -> 0, 01 -> 4, 10 -> 8, 11 -> 0
//   shift_out   - 16-bit registered result
module left_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  inp,
  input  logic [1:0]  shift_cntrl,
  output logic [15:0] shift_out
);

  // Zero-extended operand. A shift of at most 8 keeps all 8 bits inside 16 bits.
  logic [15:0] inp_ext;
  logic [15:0] next_dat;

  assign inp_ext = {8'h00, inp};

  // Code 11 maps to no shift, like 00. The default arm covers X/Z on
  // shift_cntrl and makes sure next_dat is always assigned, so no latch is inferred.
  always_comb begin
    next_dat = inp_ext;
    case (shift_cntrl)
      2'b00:   next_dat = inp_ext;
      2'b01:   next_dat = {inp_ext[11:0], 4'h0};
      2'b10:   next_dat = {inp_ext[7:0], 8'h00};
      2'b11:   next_dat = inp_ext;
      default: next_dat = inp_ext;
    endcase
  end

  // Reset takes priority over the load. A result still pending when reset
  // arrives is dropped, because nothing is held across cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_out <= 16'h0000;
    end else begin
      shift_out <= next_dat;
    end
  end

endmodule

// File: tb/tb_left_shifter.sv
module tb_left_shifter;

  logic        clk;
  logic        rst;
  logic [7:0]  inp;
  logic [1:0]  shift_cntrl;
  logic [15:0] shift_out;

  int err_cnt;
  int chk_cnt;

  left_shifter dut (
    .clk         (clk),
    .rst         (rst),
    .inp         (inp),
    .shift_cntrl (shift_cntrl),
    .shift_out   (shift_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: multiply the operand by 2**S. The shift amount comes from the code table.
  function automatic logic [15:0] ref_shift(input logic [7:0] a, input logic [1:0] c);
    int s;
    case (c)
      2'd1:    s = 4;
      2'd2:    s = 8;
      default: s = 0;
    endcase
    return 16'(int'(a) * (1 << s));
  endfunction

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Moves to 1 time unit after the next rising edge, so outputs are stable
  // and new inputs are not applied at the edge itself.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  sweep_inp;
  logic [1:0]  codes [4];
  logic [15:0] sweep_exp [4];
  logic [15:0] exp_q;

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    codes[0] = 2'b00; codes[1] = 2'b01; codes[2] = 2'b10; codes[3] = 2'b11;
    sweep_exp[0] = 16'h00AA; sweep_exp[1] = 16'h0AA0;
    sweep_exp[2] = 16'hAA00; sweep_exp[3] = 16'h00AA;

    // Reset for two edges while driving a non-zero input.
    rst = 1'b1; inp = 8'hFF; shift_cntrl = 2'b10;
    tick(); check_val("reset_edge1", shift_out, 16'h0000);
    tick(); check_val("reset_edge2", shift_out, 16'h0000);

    // Deassert reset between edges. The register must not change before the next edge.
    #2 rst = 1'b0;
    #1 check_val("rst_deassert_midcycle", shift_out, 16'h0000);
    tick(); check_val("first_load_after_rst", shift_out, 16'hFF00);

    // Sweep all codes with 8'hAA.
    sweep_inp = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      inp = sweep_inp; shift_cntrl = codes[i];
      tick();
      check_val($sformatf("sweep_AA_code%0d", i), shift_out, sweep_exp[i]);
    end

    // Boundary cases with 8'hFF.
    inp = 8'hFF; shift_cntrl = 2'b10; tick(); check_val("ff_shift8", shift_out, 16'hFF00);
    inp = 8'hFF; shift_cntrl = 2'b01; tick(); check_val("ff_shift4", shift_out, 16'h0FF0);

    // Zero input under every code.
    for (int i = 0; i < 4; i++) begin
      inp = 8'h00; shift_cntrl = codes[i];
      tick();
      check_val($sformatf("zero_code%0d", i), shift_out, 16'h0000);
    end

    // Latency check. The input changes mid-cycle, but the output holds until the edge.
    inp = 8'h01; shift_cntrl = 2'b01; tick();
    check_val("lat_before", shift_out, 16'h0010);
    inp = 8'h80;
    #2 check_val("lat_no_comb_path", shift_out, 16'h0010);
    tick();
    check_val("lat_after", shift_out, 16'h0800);

    // Reset asserted mid-stream.
    inp = 8'hAA; shift_cntrl = 2'b10; tick();
    check_val("mid_pre", shift_out, 16'hAA00);
    rst = 1'b1; inp = 8'h33; shift_cntrl = 2'b01; tick();
    check_val("mid_reset", shift_out, 16'h0000);
    rst = 1'b0; inp = 8'h5A; shift_cntrl = 2'b01; tick();
    check_val("mid_resume", shift_out, 16'h05A0);

    // Random stimulus with occasional resets. The expected value is computed before the edge.
    for (int n = 0; n < 1200; n++) begin
      inp = 8'($urandom);
      shift_cntrl = 2'($urandom);
      rst = ($urandom_range(0, 15) == 0);
      exp_q = rst ? 16'h0000 : ref_shift(inp, shift_cntrl);
      tick();
      check_val("random", shift_out, exp_q);
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/left_shifter.md
LEFT_SHIFTER -- requirements
Module: left_shifter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port `clk`: input, 1 bit, sole clock; all state updates on the rising edge.
REQ-004 Port `rst`: input, 1 bit, synchronous active-high reset; sampled on the `clk` rising edge.
REQ-005 Port `inp`: input, 8 bits, unsigned operand to be shifted.
REQ-006 Port `shift_cntrl`: input, 2 bits, shift-amount select.
REQ-007 Port `shift_out`: output, 16 bits, registered shifted result.

Function
REQ-008 The block SHALL compute `next = zero_extend16(inp) << S`, with S chosen by `shift_cntrl`:
- 2'b00: S = 0
- 2'b01: S = 4
- 2'b10: S = 8
- 2'b11: S = 0
REQ-009 Bits vacated by the shift SHALL be filled with 0.
REQ-010 Bits above the 8-bit field after the shift SHALL be 0, i.e. shift_out[15:8+S] = 0.
REQ-011 No bit of `inp` SHALL ever be lost, since the maximum shift of 8 fits in 16 bits.
REQ-012 `shift_out` SHALL be a register loaded with `next` on every rising `clk` edge when `rst` = 0; there is no enable or handshake.
REQ-013 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on `shift_out` after edge N and hold until edge N+1.
REQ-014 `shift_out` SHALL depend only on `inp` and `shift_cntrl` sampled at the same edge; there is no history or accumulation.
REQ-015 There SHALL be no combinational path from any input to `shift_out`.
REQ-016 X/Z on `shift_cntrl` is outside the operating range; the implementation SHALL still decode every one of the 4 legal codes, with no latch inferred.

Reset
REQ-017 When `rst` = 1 at a rising `clk` edge, `shift_out` SHALL become 16'h0000, regardless of `inp` and `shift_cntrl`.
REQ-018 Reset SHALL take priority over loading a new result.
REQ-019 Reset asserted mid-stream SHALL discard the pending result; the first edge with `rst` = 0 SHALL load the then-current `inp`/`shift_cntrl` result.
REQ-020 `shift_out` is undefined before the first reset edge; the bench SHALL apply reset for at least 1 cycle before checking outputs.
REQ-021 Deasserting `rst` between clock edges SHALL have no effect until the next rising edge.

Verification
REQ-022 Reset: `rst` = 1 for 2 cycles with `inp` = 8'hFF, `shift_cntrl` = 2'b10 -> `shift_out` = 16'h0000 after each reset edge.
REQ-023 Sweep with `inp` = 8'hAA, one code per cycle -> `shift_out` one cycle later:
- 2'b00 -> 16'h00AA
- 2'b01 -> 16'h0AA0
- 2'b10 -> 16'hAA00
- 2'b11 -> 16'h00AA
REQ-024 Boundaries, `inp` = 8'hFF:
- 2'b10 -> 16'hFF00
- 2'b01 -> 16'h0FF0
REQ-025 Boundaries, `inp` = 8'h00 under every code -> 16'h0000.
REQ-026 Latency: change `inp` from 8'h01 to 8'h80 at edge N with `shift_cntrl` = 2'b01:
- `shift_out` shows 16'h0010 during cycle N-1→N
- `shift_out` shows 16'h0800 after edge N
REQ-027 Reset mid-stream: `shift_out` = 16'hAA00, assert `rst` for one edge -> 16'h0000; next edge with `rst` = 0, `inp` = 8'h5A, `shift_cntrl` = 2'b01 -> 16'h05A0.
REQ-028 Random: at least 1000 random `inp`/`shift_cntrl` pairs SHALL be compared against a reference model delayed by one cycle, with zero mismatches.
